// File: rtl/alu_pwr_ctrl_pkg.sv
// Shared definitions for the ALU power-sequencing controller: state encodings
// and default delay constants.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    PS_OFF     = 3'd0,
    PS_PWR_UP  = 3'd1,
    PS_ISO_REL = 3'd2,
    PS_ON      = 3'd3,
    PS_ISO_SET = 3'd4
  } pwr_state_e;

  // Plain constants for the state register, kept in step with the enum above.
  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_PWR_UP  = 3'd1;
  localparam logic [2:0] ST_ISO_REL = 3'd2;
  localparam logic [2:0] ST_ON      = 3'd3;
  localparam logic [2:0] ST_ISO_SET = 3'd4;

  localparam int DEF_IDLE_TIMEOUT = 16;
  localparam int DEF_PWR_UP_DLY   = 4;
  localparam int DEF_ISO_HOLD     = 1;
  localparam int DEF_ISO_SETUP    = 2;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/alu_pwr_ctrl_if.sv
// Request/power-control bundle between the op issuer, the ALU domain pins
// and the power-sequencing controller.
interface alu_pwr_ctrl_if;

  logic       op_req;
  logic       op_ack;
  logic       sleep_req;
  logic       wake_req;
  logic       alu_busy;
  logic       alu_start;
  logic       alu_pwr_en;
  logic       iso_en;
  logic       alu_dom_rst;
  logic       pwr_on;
  logic [2:0] pwr_state;

  // master: requester plus ALU domain side; slave: the controller
  modport master (
    output op_req, sleep_req, wake_req, alu_busy,
    input  op_ack, alu_start, alu_pwr_en, iso_en, alu_dom_rst, pwr_on, pwr_state
  );

  modport slave (
    input  op_req, sleep_req, wake_req, alu_busy,
    output op_ack, alu_start, alu_pwr_en, iso_en, alu_dom_rst, pwr_on, pwr_state
  );

endinterface

// File: rtl/alu_pwr_ctrl_pwr_dly_timer.sv
// Loadable down-counter shared by every timed power state; done is high
// whenever the count reads zero.
module pwr_dly_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing controller for the gated ALU domain: wakes on demand,
// gates the ALU start strobe, and powers down on sleep request or idle timeout.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int PWR_UP_DLY   = DEF_PWR_UP_DLY,
  parameter int ISO_HOLD     = DEF_ISO_HOLD,
  parameter int ISO_SETUP    = DEF_ISO_SETUP,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst,
  alu_pwr_ctrl_if.slave bus
);

  // Timer reload values: a state lasting N cycles exits on the cycle the count reads 0.
  localparam logic [CNT_W-1:0] PU_LD   = CNT_W'(PWR_UP_DLY - 1);
  localparam logic [CNT_W-1:0] IR_LD   = CNT_W'(ISO_HOLD - 1);
  localparam logic [CNT_W-1:0] IS_LD   = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] IT_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic             IT_EN   = (IDLE_TIMEOUT != 0);

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_load;
  logic             tmr_done;
  logic             ack;
  logic             idle_now;
  logic             idle_hit;

  assign idle_now = !bus.op_req && !bus.alu_busy;
  assign idle_hit = IT_EN && idle_now && (idle_cnt >= IT_LAST);

  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    case (state)
      ST_OFF: begin
        if (bus.op_req || bus.wake_req) state_nxt = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (tmr_done) state_nxt = ST_ISO_REL;
      end
      ST_ISO_REL: begin
        if (tmr_done) state_nxt = ST_ON;
      end
      ST_ON: begin
        // Busy blocks both sleep and ack; sleep outranks a pending op.
        if (!bus.alu_busy) begin
          if (bus.sleep_req) begin
            state_nxt = ST_ISO_SET;
          end else if (bus.op_req) begin
            ack = 1'b1;
          end else if (idle_hit) begin
            state_nxt = ST_ISO_SET;
          end
        end
      end
      ST_ISO_SET: begin
        if (tmr_done) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_comb begin
    tmr_load = (state_nxt != state);
    case (state_nxt)
      ST_PWR_UP:  tmr_val = PU_LD;
      ST_ISO_REL: tmr_val = IR_LD;
      ST_ISO_SET: tmr_val = IS_LD;
      default:    tmr_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  pwr_dly_timer #(
    .CNT_W (CNT_W)
  ) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Held at zero outside ON, so entering ON always starts a fresh idle count.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state != ST_ON) || !idle_now) begin
      idle_cnt <= '0;
    end else if (idle_cnt != '1) begin
      idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end

  assign bus.op_ack      = ack && !rst;
  assign bus.alu_start   = ack && !rst;
  assign bus.alu_pwr_en  = (state != ST_OFF);
  assign bus.iso_en      = (state != ST_ON);
  assign bus.alu_dom_rst = (state == ST_OFF) || (state == ST_PWR_UP);
  assign bus.pwr_on      = (state == ST_ON);
  assign bus.pwr_state   = state;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Bench for alu_pwr_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against a phase/duration reference model.
module tb_alu_pwr_ctrl;
  import alu_pwr_pkg::*;

  localparam int TO  = DEF_IDLE_TIMEOUT;
  localparam int PUD = DEF_PWR_UP_DLY;
  localparam int IH  = DEF_ISO_HOLD;
  localparam int IS  = DEF_ISO_SETUP;

  // Output vector layout: {op_ack, alu_start, alu_pwr_en, iso_en, alu_dom_rst, pwr_on, pwr_state}
  localparam logic [8:0] V_OFF = 9'b000110000;
  localparam logic [8:0] V_PU  = 9'b001110001;
  localparam logic [8:0] V_IR  = 9'b001100010;
  localparam logic [8:0] V_ON  = 9'b001001011;
  localparam logic [8:0] V_ONA = 9'b111001011;

  typedef struct {
    logic       r, o, s, w, b;
    logic [8:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t tbl[$];

  logic cur_r, cur_o, cur_s, cur_w, cur_b;
  int   m_ph, m_age, m_idle;

  alu_pwr_ctrl_if bus ();
  alu_pwr_ctrl_if bus_nt ();

  alu_pwr_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  alu_pwr_ctrl #(
    .IDLE_TIMEOUT (0)
  ) dut_nt (
    .clk (clk),
    .rst (rst),
    .bus (bus_nt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] outv();
    return {bus.op_ack, bus.alu_start, bus.alu_pwr_en, bus.iso_en,
            bus.alu_dom_rst, bus.pwr_on, bus.pwr_state};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive_in(input logic r, input logic o, input logic s, input logic w, input logic b);
    cur_r = r; cur_o = o; cur_s = s; cur_w = w; cur_b = b;
    rst = r;
    bus.op_req = o;    bus.sleep_req = s;    bus.wake_req = w;    bus.alu_busy = b;
    bus_nt.op_req = o; bus_nt.sleep_req = s; bus_nt.wake_req = w; bus_nt.alu_busy = b;
  endtask

  // Phase durations and successors in the power sequence.
  function automatic int dur(input int ph);
    case (ph)
      1: return PUD;
      2: return IH;
      4: return IS;
      default: return 1;
    endcase
  endfunction

  function automatic int succ(input int ph);
    return (ph == 4) ? 0 : ph + 1;
  endfunction

  function automatic logic [8:0] model_out();
    logic a;
    a = !cur_r && (m_ph == 3) && cur_o && !cur_b && !cur_s;
    return {a, a, m_ph != 0, m_ph != 3, m_ph <= 1, m_ph == 3, 3'(m_ph)};
  endfunction

  task automatic enter(input int ph);
    m_ph = ph; m_age = 0; m_idle = 0;
  endtask

  task automatic model_adv();
    if (cur_r) begin
      enter(0);
    end else begin
      case (m_ph)
        0: if (cur_o || cur_w) enter(1);
        1, 2, 4: begin
          if (m_age + 1 >= dur(m_ph)) enter(succ(m_ph));
          else m_age++;
        end
        3: begin
          if (!cur_b && cur_s) begin
            enter(4);
          end else if (cur_o || cur_b) begin
            m_idle = 0;
          end else begin
            m_idle++;
            if (TO != 0 && m_idle >= TO) enter(4);
          end
        end
        default: enter(0);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_check(input string nm);
    #1;
    chk(nm, outv(), model_out());
  endtask

  task automatic end_cycle();
    model_adv();
    tick();
  endtask

  task automatic reset_all();
    drive_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk("reset_state", outv(), V_OFF);
    tick();
    enter(0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    enter(0);

    // Wake on op, busy stall, back-to-back acks.
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_OFF});
    for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_PU});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_IR});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ONA});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, V_ON});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ONA});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ONA});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ON});

    reset_all();
    for (int i = 0; i < tbl.size(); i++) begin
      drive_in(tbl[i].r, tbl[i].o, tbl[i].s, tbl[i].w, tbl[i].b);
      #1;
      chk($sformatf("vec%0d", i), outv(), tbl[i].exp);
      end_cycle();
    end

    // Idle timeout after a wake_req-only power-up; the no-timeout instance stays ON.
    reset_all();
    for (int c = 0; c < 46; c++) begin
      drive_in(1'b0, 1'b0, 1'b0, c == 0, 1'b0);
      settle_check("idle_seq");
      if (c == 21) chk("idle_still_on_21", bus.pwr_state, 3'd3);
      if (c == 22) chk("idle_iso_set_22", {bus.pwr_state, bus.iso_en}, {3'd4, 1'b1});
      if (c == 23) chk("idle_pwr_en_23", bus.alu_pwr_en, 1'b1);
      if (c == 24) chk("idle_pwr_off_24", bus.alu_pwr_en, 1'b0);
      if (c == 6 || c == 22 || c == 45) chk($sformatf("no_timeout_on_%0d", c), bus_nt.pwr_on, 1'b1);
      end_cycle();
    end

    // Sleep and op together in ON: sleep wins, held op re-wakes the domain.
    reset_all();
    for (int c = 0; c < 18; c++) begin
      drive_in(1'b0, (c >= 6) && (c <= 15), c == 6, c == 0, 1'b0);
      settle_check("sleep_seq");
      if (c == 6)  chk("sleep_no_ack", bus.op_ack, 1'b0);
      if (c == 7)  chk("sleep_iso_set", bus.pwr_state, 3'd4);
      if (c == 9)  chk("sleep_off", {bus.pwr_state, bus.alu_pwr_en}, {3'd0, 1'b0});
      if (c == 10) chk("rewake_pwr_up", bus.pwr_state, 3'd1);
      if (c == 14) chk("rewake_no_ack_yet", bus.op_ack, 1'b0);
      if (c == 15) chk("rewake_ack", {bus.op_ack, bus.alu_start}, 2'b11);
    end_cycle();
    end

    // Reset pulse in the second PWR_UP cycle, then a full-length wake.
    reset_all();
    for (int c = 0; c < 11; c++) begin
      drive_in(c == 2, c <= 9, 1'b0, 1'b0, 1'b0);
      settle_check("rst_mid_seq");
      if (c == 2) chk("rst_mid_in_pu", bus.pwr_state, 3'd1);
      if (c == 3) chk("rst_mid_off", outv(), V_OFF);
      if (c == 8) chk("rst_rewake_no_ack", bus.op_ack, 1'b0);
      if (c == 9) chk("rst_rewake_ack", outv(), V_ONA);
      end_cycle();
    end

    // Randomized traffic against the reference model.
    reset_all();
    for (int c = 0; c < 3000; c++) begin
      drive_in($urandom_range(0, 63) == 0,
               $urandom_range(0, 9) < 4,
               $urandom_range(0, 19) == 0,
               $urandom_range(0, 9) < 2,
               $urandom_range(0, 9) < 3);
      settle_check("random");
      end_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
